bec_ladder_sequencer: RTL
=========================

# bec_ladder_sequencer

Sequencer that drives one `sm_bec_v3` binary-Edwards-curve ladder core through a full scalar-multiplication run. It latches a 163-bit key and presents it LSB-first on the core's key-bit input, advancing on each `next_key` request. It bounds and counts the iterations, captures the W/Z result on completion, and reports `busy`/`done`/`error` to the logic-analyzer front end. It sits between the LA register file and the core and replaces ad-hoc enable/key-shift handling there.

## Interface
- `KEY_W`, 163: key and coordinate width in bits.
- `TIMEOUT`, 4095: maximum RUN cycles without `core_done` before abort (only used with `BEC_TIMEOUT_EN`).
- `wb_clk_i`  in  1  single clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `key_in`  in  KEY_W  scalar; latched when `start` is accepted.
- `core_next_key`  in  1  core requests the next key bit.
- `core_done`  in  1  core finished; `wout_in`/`zout_in` valid this cycle.
- `wout_in`, `zout_in`  in  KEY_W each  core result buses.
- `core_en`  out  1  core enable; high exactly while in RUN.
- `core_ki`  out  1  current key bit, `key_sr[0]`.
- `wout`, `zout`  out  KEY_W each  captured results; held until the next accepted `start`.
- `bit_cnt`  out  8  key bits consumed in the current or last run.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  sticky fault flag; cleared by an accepted `start` or by reset.

## Operation
- States: IDLE, RUN, DONE. Encoding is free. There is no separate error state; a fault sets `error` and returns to IDLE.
- IDLE:
  - `core_en=0`, `busy=0`.
  - `start=1` → `key_sr<=key_in`, `bit_cnt<=0`, `error<=0`, `wout/zout<=0`, cycle counter `<=0`, then → RUN.
- RUN:
  - `core_en=1`, `busy=1`, `core_ki=key_sr[0]`.
  - `core_next_key=1` with `bit_cnt<KEY_W`: `key_sr<=key_sr>>1` with zero fill, `bit_cnt<=bit_cnt+1`.
  - `core_next_key=1` with `bit_cnt==KEY_W` (overrun): `error<=1`, → IDLE. `wout/zout` are not updated.
  - `core_done=1`: `wout<=wout_in`, `zout<=zout_in`, → DONE. If `core_next_key` is asserted in the same cycle, done takes priority and no shift or count occurs.
- DONE: `done=1` for this single cycle, `core_en=0`, `busy=0`, then unconditionally → IDLE. `start` is ignored in DONE.
- `start` asserted in RUN or DONE is ignored, with no effect on the key, counters or flags.
- `bit_cnt` is 8 bits wide and never exceeds KEY_W (163); it does not wrap.

## Timing
- Reset: state IDLE.
  - All outputs are 0: `core_en`, `core_ki`, `busy`, `done`, `error`, `bit_cnt`, `wout`, `zout`.
  - `key_sr` and the cycle counter are also 0.
- Reset asserted in any state → IDLE at that edge; `core_en` is low the following cycle.
- `start` sampled high at edge N → `busy=core_en=1` and `core_ki=key_in[0]` from N+1.
- `core_next_key` at edge K → the updated `core_ki` and `bit_cnt` are visible from K+1. The core must not rely on the new bit within the same cycle.
- `core_done` at edge M:
  - from M+1: `wout/zout` valid, `done=1`, `busy=0`, `core_en=0`;
  - from M+2: IDLE, where a new `start` is accepted.
- Fault (overrun or timeout) at edge F → `error=1` and `core_en=0` from F+1; IDLE from F+1.
- All outputs are registered except `core_ki`, which is a direct wire from `key_sr[0]`.

## Configuration
- `BEC_TIMEOUT_EN` defined:
  - A 12-bit cycle counter increments every RUN cycle.
  - When it reaches `TIMEOUT` without `core_done` → `error<=1`, → IDLE.
  - A `core_done` arriving in the same cycle as the terminal count wins: it counts as a normal completion.
- `BEC_TIMEOUT_EN` undefined: no counter is built, `TIMEOUT` is ignored, and RUN waits for `core_done` indefinitely. Overrun detection is always present.

## Test plan
- Reset, then idle 10 cycles → every output 0 and `core_en` never high.
- Normal run: `key_in=163'h5`, `start`; core model pulses `next_key` 163 times, then `core_done` with `wout_in=163'h1234`, `zout_in=163'h5678`.
  - `core_ki` sequence: 1,0,1,0,…0.
  - Final `bit_cnt=163`.
  - `done` pulses once, one cycle after `core_done`.
  - `wout=163'h1234`, `zout=163'h5678`.
  - `error=0`.
- Overrun: 164th `next_key` pulse → `error=1` next cycle, `core_en=0`, `wout` stays 0, `done` never pulses.
- Simultaneous `next_key` and `core_done` at `bit_cnt=100` → `bit_cnt` stays 100, result captured, `done=1`.
- `start` pulsed mid-RUN with a different key → `core_ki` stream and `bit_cnt` unaffected. Reset asserted at `bit_cnt=50` → all outputs 0 next cycle.
- With `BEC_TIMEOUT_EN` and `TIMEOUT=20`: `start` with no `core_done` → `error=1` after 20 RUN cycles. A subsequent `start` clears `error` and runs normally.

Source files
------------

// File: rtl/bec_ladder_sequencer.sv
// bec_ladder_sequencer: drives one sm_bec_v3 ladder core through a scalar
// multiplication. Latches the key, feeds it LSB-first on core_ki, counts the
// consumed bits, captures W/Z on completion and flags overrun faults.
// Optional feature macro: BEC_TIMEOUT_EN adds a 12-bit RUN-cycle watchdog
// that aborts the run after TIMEOUT cycles without core_done.
module bec_ladder_sequencer #(
    parameter int unsigned KEY_W   = 163,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             core_next_key,
    input  logic             core_done,
    input  logic [KEY_W-1:0] wout_in,
    input  logic [KEY_W-1:0] zout_in,
    output logic             core_en,
    output logic             core_ki,
    output logic [KEY_W-1:0] wout,
    output logic [KEY_W-1:0] zout,
    output logic [7:0]       bit_cnt,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Last legal count; a next_key request here means the core overran the key.
    localparam logic [7:0] LP_CNT_MAX = 8'(KEY_W);

    state_e           r_state;
    logic [KEY_W-1:0] r_key_sr;
    logic [KEY_W-1:0] r_wout;
    logic [KEY_W-1:0] r_zout;
    logic [7:0]       r_bit_cnt;
    logic             r_core_en;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

`ifdef BEC_TIMEOUT_EN
    // Count value seen on the TIMEOUT-th RUN cycle.
    localparam logic [11:0] LP_TO_LAST = 12'(TIMEOUT - 1);
    logic [11:0] r_cyc;
`endif

    // Sequencer FSM with all registered outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= StIdle;
            r_key_sr  <= '0;
            r_wout    <= '0;
            r_zout    <= '0;
            r_bit_cnt <= '0;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
`ifdef BEC_TIMEOUT_EN
            r_cyc     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_key_sr  <= key_in;
                        r_bit_cnt <= '0;
                        r_error   <= 1'b0;
                        r_wout    <= '0;
                        r_zout    <= '0;
`ifdef BEC_TIMEOUT_EN
                        r_cyc     <= '0;
`endif
                        r_core_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= StRun;
                    end
                end
                StRun: begin
                    if (core_done) begin
                        // Completion wins over a coincident next_key or timeout.
                        r_wout    <= wout_in;
                        r_zout    <= zout_in;
                        r_done    <= 1'b1;
                        r_core_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= StDone;
                    end else if (core_next_key && (r_bit_cnt == LP_CNT_MAX)) begin
                        r_error   <= 1'b1;
                        r_core_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
`ifdef BEC_TIMEOUT_EN
                    end else if (r_cyc == LP_TO_LAST) begin
                        r_error   <= 1'b1;
                        r_core_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= StIdle;
`endif
                    end else begin
                        if (core_next_key) begin
                            r_key_sr  <= r_key_sr >> 1;
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
`ifdef BEC_TIMEOUT_EN
                        r_cyc <= r_cyc + 12'd1;
`endif
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_core_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign core_en = r_core_en;
    assign core_ki = r_key_sr[0];
    assign wout    = r_wout;
    assign zout    = r_zout;
    assign bit_cnt = r_bit_cnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign error   = r_error;

endmodule
